controller_fetch: RTL and testbench

- Serial reader for two SNES-style game controllers.
- Consumes the GPU's controller_start_fetch_o pulse, generated once per frame during scanline 0.
- Drives the shared latch and clock lines and shifts in 16 bits from each controller's data line.
- Publishes per-frame button words, active-high, to the CPU-side input registers.

---
 rtl/controller_fetch_if.sv | 41 ++++
 rtl/controller_fetch.sv | 130 +++++++++++++
 tb/tb_controller_fetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_fetch_if.sv
// Bus bundle between the GPU/controller pins and controller_fetch.
// CONTROLLER_FETCH_EDGES_EN adds the newly-pressed button words.
interface controller_fetch_if #(
   parameter int NUM_BITS = 16
);
   logic                start_fetch_i;
   logic                controller_data_1_i;
   logic                controller_data_2_i;
   logic                controller_latch_o;
   logic                controller_clk_o;
   logic [NUM_BITS-1:0] buttons_1_o;
   logic [NUM_BITS-1:0] buttons_2_o;
   logic                valid_o;
   logic                busy_o;
`ifdef CONTROLLER_FETCH_EDGES_EN
   logic [NUM_BITS-1:0] pressed_1_o;
   logic [NUM_BITS-1:0] pressed_2_o;

   modport master (
      output start_fetch_i, controller_data_1_i, controller_data_2_i,
      input  controller_latch_o, controller_clk_o, buttons_1_o, buttons_2_o,
      input  valid_o, busy_o, pressed_1_o, pressed_2_o
   );
   modport slave (
      input  start_fetch_i, controller_data_1_i, controller_data_2_i,
      output controller_latch_o, controller_clk_o, buttons_1_o, buttons_2_o,
      output valid_o, busy_o, pressed_1_o, pressed_2_o
   );
`else
   modport master (
      output start_fetch_i, controller_data_1_i, controller_data_2_i,
      input  controller_latch_o, controller_clk_o, buttons_1_o, buttons_2_o,
      input  valid_o, busy_o
   );
   modport slave (
      input  start_fetch_i, controller_data_1_i, controller_data_2_i,
      output controller_latch_o, controller_clk_o, buttons_1_o, buttons_2_o,
      output valid_o, busy_o
   );
`endif
endinterface

// File: rtl/controller_fetch.sv
// Serial reader for two SNES-style controllers: one latch + NUM_BITS clock pulses per GPU start edge.
// Define CONTROLLER_FETCH_EDGES_EN to add pressed_*_o (buttons newly pressed since the last fetch).
module controller_fetch #(
   parameter int LATCH_CYCLES = 151,
   parameter int HALF_PERIOD  = 76,
   parameter int NUM_BITS     = 16
) (
   input logic               gpu_clk,
   input logic               rst,
   controller_fetch_if.slave bus
);
   localparam int PH_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int IDX_W  = $clog2(NUM_BITS) + 1;
   localparam int SEL_W  = $clog2(NUM_BITS);

   localparam logic [PH_W-1:0]  LATCH_LOAD = PH_W'(LATCH_CYCLES - 1);
   localparam logic [PH_W-1:0]  HALF_LOAD  = PH_W'(HALF_PERIOD - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BITS);

   typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

   state_t              state, state_d;
   logic [PH_W-1:0]     ph_cnt;
   logic [IDX_W-1:0]    idx;
   logic                start_q, start_edge_q;
   logic                d1_meta, d1_sync, d2_meta, d2_sync;
   logic [NUM_BITS-1:0] shift_1, shift_2;
   logic                phase_last;
   logic                latch_d, clk_d, valid_d, busy_d;

   assign phase_last = (ph_cnt == '0);

   always_ff @(posedge gpu_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start_edge_q) state_d = LATCH;
         LATCH:   if (phase_last)   state_d = LOW;
         LOW:     if (phase_last)   state_d = HIGH;
         HIGH:    if (phase_last)   state_d = (idx < LAST_IDX) ? LOW : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Pin values are decoded from the next state so they change on the same edge as the state.
      latch_d = (state_d == LATCH);
      clk_d   = (state_d != LOW);
      valid_d = (state_d == DONE);
      busy_d  = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge gpu_clk or posedge rst) begin
      if (rst) begin
         start_q                <= 1'b0;
         start_edge_q           <= 1'b0;
         d1_meta                <= 1'b1;
         d1_sync                <= 1'b1;
         d2_meta                <= 1'b1;
         d2_sync                <= 1'b1;
         ph_cnt                 <= '0;
         idx                    <= '0;
         shift_1                <= '0;
         shift_2                <= '0;
         bus.controller_latch_o <= 1'b0;
         bus.controller_clk_o   <= 1'b1;
         bus.valid_o            <= 1'b0;
         bus.busy_o             <= 1'b0;
         bus.buttons_1_o        <= '0;
         bus.buttons_2_o        <= '0;
`ifdef CONTROLLER_FETCH_EDGES_EN
         bus.pressed_1_o        <= '0;
         bus.pressed_2_o        <= '0;
`endif
      end else begin
         start_q      <= bus.start_fetch_i;
         start_edge_q <= bus.start_fetch_i & ~start_q;
         d1_meta      <= bus.controller_data_1_i;
         d1_sync      <= d1_meta;
         d2_meta      <= bus.controller_data_2_i;
         d2_sync      <= d2_meta;

         bus.controller_latch_o <= latch_d;
         bus.controller_clk_o   <= clk_d;
         bus.valid_o            <= valid_d;
         bus.busy_o             <= busy_d;

         // Phase counter counts down from the reload value and parks at zero.
         if (state_d != state) begin
            case (state_d)
               LATCH:    ph_cnt <= LATCH_LOAD;
               LOW:      ph_cnt <= HALF_LOAD;
               HIGH:     ph_cnt <= HALF_LOAD;
               default:  ph_cnt <= '0;
            endcase
         end else if (!phase_last) begin
            ph_cnt <= ph_cnt - PH_W'(1);
         end

         if (state == IDLE && state_d == LATCH) idx <= '0;

         if (state == LATCH && phase_last) begin
            shift_1[0] <= d1_sync;
            shift_2[0] <= d2_sync;
            idx        <= IDX_W'(1);
         end

         if (state == HIGH && phase_last && idx < LAST_IDX) begin
            shift_1[idx[SEL_W-1:0]] <= d1_sync;
            shift_2[idx[SEL_W-1:0]] <= d2_sync;
            idx                     <= idx + IDX_W'(1);
         end

         // Buttons are active-low on the wire; publish only on DONE entry.
         if (state != DONE && state_d == DONE) begin
            bus.buttons_1_o <= ~shift_1;
            bus.buttons_2_o <= ~shift_2;
`ifdef CONTROLLER_FETCH_EDGES_EN
            bus.pressed_1_o <= ~shift_1 & ~bus.buttons_1_o;
            bus.pressed_2_o <= ~shift_2 & ~bus.buttons_2_o;
`endif
         end
      end
   end
endmodule

// File: tb/tb_controller_fetch.sv
// Self-checking bench for controller_fetch with small timing parameters and an emulated pair of controllers.
// With CONTROLLER_FETCH_EDGES_EN defined it also checks the newly-pressed outputs.
module tb_controller_fetch;
   localparam int LAT_C = 4;
   localparam int HALF  = 2;
   localparam int NB    = 16;
   localparam int LAT   = 1 + LAT_C + 2 * NB * HALF;

   logic gpu_clk = 1'b0;
   logic rst     = 1'b1;
   logic d1      = 1'b1;
   logic d2      = 1'b1;

   int checks = 0;
   int errors = 0;

   controller_fetch_if #(.NUM_BITS(NB)) bus ();

   controller_fetch #(
      .LATCH_CYCLES(LAT_C),
      .HALF_PERIOD (HALF),
      .NUM_BITS    (NB)
   ) dut (
      .gpu_clk(gpu_clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 gpu_clk = ~gpu_clk;

   assign bus.controller_data_1_i = d1;
   assign bus.controller_data_2_i = d2;

   // Controller emulation: pressed masks, bit n driven (active-low) after n falling clock edges since latch.
   // Bits are put on the line at the falling edge so they are settled well before the sample point.
   logic [15:0] pad1 = '0;
   logic [15:0] pad2 = '0;
   int          fall_cnt = NB;

   always @(posedge bus.controller_latch_o or negedge bus.controller_clk_o) begin
      if (bus.controller_latch_o) fall_cnt = 0;
      else                        fall_cnt++;
      if (fall_cnt < NB) begin
         d1 = ~pad1[fall_cnt[3:0]];
         d2 = ~pad2[fall_cnt[3:0]];
      end else begin
         d1 = 1'b1;
         d2 = 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-fetch observations gathered on falling gpu_clk edges.
   int latch_cyc, falls, low_cyc, bad_low, valid_cnt, valid_at, busy_cyc;

   task automatic run_fetch(input logic [15:0] m1, input logic [15:0] m2,
                            input int len1, input int retrig);
      int   win;
      int   cur_low;
      logic prev_clk;
      pad1 = m1;
      pad2 = m2;
      latch_cyc = 0; falls = 0; low_cyc = 0; bad_low = 0;
      valid_cnt = 0; valid_at = -1; busy_cyc = 0;
      win = ((len1 > retrig + 10) ? len1 : retrig + 10) + 100;
      prev_clk = 1'b1;
      cur_low  = 0;
      @(negedge gpu_clk);
      bus.start_fetch_i = 1'b1;
      for (int n = 0; n < win; n++) begin
         @(negedge gpu_clk);
         if (bus.controller_latch_o) latch_cyc++;
         if (bus.busy_o) busy_cyc++;
         if (!bus.controller_clk_o) begin
            low_cyc++;
            cur_low++;
            if (prev_clk) falls++;
         end else if (!prev_clk) begin
            if (cur_low != HALF) bad_low++;
            cur_low = 0;
         end
         if (bus.valid_o) begin
            valid_cnt++;
            if (valid_at < 0) valid_at = n;
         end
         prev_clk = bus.controller_clk_o;
         bus.start_fetch_i = ((n + 1) < len1) ||
                             (retrig >= 0 && (n + 1) >= retrig && (n + 1) < retrig + 10);
      end
   endtask

   task automatic check_fetch(input string name, input logic [15:0] exp1, input logic [15:0] exp2);
      check({name, "_latch_cycles"}, latch_cyc, LAT_C);
      check({name, "_falling_edges"}, falls, NB);
      check({name, "_low_cycles"}, low_cyc, NB * HALF);
      check({name, "_bad_low_len"}, bad_low, 0);
      check({name, "_valid_count"}, valid_cnt, 1);
      check({name, "_valid_latency"}, valid_at, LAT);
      check({name, "_busy_cycles"}, busy_cyc, LAT);
      check({name, "_buttons_1"}, {16'h0, bus.buttons_1_o}, {16'h0, exp1});
      check({name, "_buttons_2"}, {16'h0, bus.buttons_2_o}, {16'h0, exp2});
      check({name, "_idle_after"}, {31'h0, bus.busy_o}, 0);
   endtask

   typedef struct {
      string       name;
      logic [15:0] m1;
      logic [15:0] m2;
      int          len1;
      int          retrig;
      logic [15:0] exp1;
      logic [15:0] exp2;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int          act_cnt;
      int          found;
      logic [15:0] prev1, prev2;
      logic [15:0] r1, r2;

      bus.start_fetch_i = 1'b0;

      // Table: fixed cases from the plan, random presses, and the all-pressed controller 2 case last.
      vecs[0] = '{"basic",   16'h0009, 16'h0000, 32,  -1, 16'h0009, 16'h0000};
      vecs[1] = '{"retrig",  16'h8001, 16'h0100, 10,  20, 16'h8001, 16'h0100};
      vecs[2] = '{"held200", 16'hFFFF, 16'h1234, 200, -1, 16'hFFFF, 16'h1234};
      for (int i = 3; i < 6; i++) begin
         r1 = 16'($urandom);
         r2 = 16'($urandom);
         // Reference: the published word is exactly the set of held buttons, 1 = pressed.
         vecs[i] = '{$sformatf("rand%0d", i), r1, r2, 32, -1, r1, r2};
      end
      vecs[6] = '{"all2",    16'h0000, 16'hFFFF, 32,  -1, 16'h0000, 16'hFFFF};

      // Reset state
      repeat (3) @(negedge gpu_clk);
      check("rst_latch",   {31'h0, bus.controller_latch_o}, 0);
      check("rst_clk",     {31'h0, bus.controller_clk_o}, 1);
      check("rst_valid",   {31'h0, bus.valid_o}, 0);
      check("rst_busy",    {31'h0, bus.busy_o}, 0);
      check("rst_buttons", {bus.buttons_1_o, bus.buttons_2_o}, 0);
      rst = 1'b0;

      // Idle with start low: no pin activity at all.
      act_cnt = 0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge gpu_clk);
         if (bus.controller_latch_o || !bus.controller_clk_o || bus.valid_o || bus.busy_o)
            act_cnt++;
      end
      check("idle_activity", act_cnt, 0);

      // Reset during the 5th LOW phase.
      pad1 = 16'hFFFF;
      pad2 = 16'hFFFF;
      found = 0;
      act_cnt = 0;
      @(negedge gpu_clk);
      bus.start_fetch_i = 1'b1;
      for (int n = 0; n < 200 && found == 0; n++) begin
         @(negedge gpu_clk);
         if (!bus.controller_clk_o && act_cnt == 0) begin
            act_cnt = 1;
            falls++;
         end
         if (bus.controller_clk_o) act_cnt = 0;
         if (n == 0) falls = 0;
         if (falls == 5 && !bus.controller_clk_o) begin
            found = 1;
            rst = 1'b1;
            bus.start_fetch_i = 1'b0;
            #1;
            check("midrst_latch", {31'h0, bus.controller_latch_o}, 0);
            check("midrst_clk",   {31'h0, bus.controller_clk_o}, 1);
            check("midrst_busy",  {31'h0, bus.busy_o}, 0);
            check("midrst_valid", {31'h0, bus.valid_o}, 0);
         end
      end
      check("midrst_reached", found, 1);
      rst = 1'b1;
      bus.start_fetch_i = 1'b0;
      repeat (3) @(negedge gpu_clk);
      rst = 1'b0;
      act_cnt = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge gpu_clk);
         if (bus.valid_o || bus.busy_o) act_cnt++;
      end
      check("midrst_no_fetch", act_cnt, 0);
      check("midrst_buttons", {bus.buttons_1_o, bus.buttons_2_o}, 0);

      // Table-driven fetches.
      prev1 = '0;
      prev2 = '0;
      for (int i = 0; i < 7; i++) begin
         run_fetch(vecs[i].m1, vecs[i].m2, vecs[i].len1, vecs[i].retrig);
         check_fetch(vecs[i].name, vecs[i].exp1, vecs[i].exp2);
`ifdef CONTROLLER_FETCH_EDGES_EN
         check({vecs[i].name, "_pressed_1"}, {16'h0, bus.pressed_1_o}, {16'h0, vecs[i].exp1 & ~prev1});
         check({vecs[i].name, "_pressed_2"}, {16'h0, bus.pressed_2_o}, {16'h0, vecs[i].exp2 & ~prev2});
`endif
         prev1 = vecs[i].exp1;
         prev2 = vecs[i].exp2;
      end

      // Hold: no start for 500 cycles keeps the last words.
      act_cnt = 0;
      for (int n = 0; n < 500; n++) begin
         @(negedge gpu_clk);
         if (bus.valid_o) act_cnt++;
      end
      check("hold_no_valid", act_cnt, 0);
      check("hold_buttons_2", {16'h0, bus.buttons_2_o}, 32'h0000FFFF);
      check("hold_buttons_1", {16'h0, bus.buttons_1_o}, 0);

`ifdef CONTROLLER_FETCH_EDGES_EN
      // Newly-pressed sequence from a fresh reset.
      rst = 1'b1;
      repeat (2) @(negedge gpu_clk);
      check("edges_rst_pressed", {bus.pressed_1_o, bus.pressed_2_o}, 0);
      rst = 1'b0;
      run_fetch(16'h0008, 16'h0000, 32, -1);
      check("edges_f1_pressed_1", {16'h0, bus.pressed_1_o}, 32'h0008);
      run_fetch(16'h0028, 16'h0000, 32, -1);
      check("edges_f2_pressed_1", {16'h0, bus.pressed_1_o}, 32'h0020);
      run_fetch(16'h0000, 16'h0000, 32, -1);
      check("edges_f3_pressed_1", {16'h0, bus.pressed_1_o}, 32'h0000);
      check("edges_f3_buttons_1", {16'h0, bus.buttons_1_o}, 32'h0000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
